// File: rtl/clock_key_ctrl_pkg.sv
// Shared constants for the clock key front-end: key indices, repeat FSM
// state encodings and default timing parameters.
package clock_pkg;

  localparam int K_MODE   = 0;
  localparam int K_SELECT = 1;
  localparam int K_ADJUST = 2;
  localparam int NKEYS    = 3;

  typedef enum logic [1:0] {
    R_IDLE   = 2'b00,
    R_DELAY  = 2'b01,
    R_REPEAT = 2'b10,
    R_LOCK   = 2'b11
  } rep_state_e;

  localparam int DEF_DBNC   = 3;
  localparam int DEF_REPDLY = 50;
  localparam int DEF_REPINT = 10;
  localparam int DEF_CW     = 8;

endpackage

// File: rtl/clock_key_ctrl_if.sv
// Sample strobe, raw buttons and command pulses shared between the key
// front-end (slave) and whoever drives the buttons (master).
interface clock_key_ctrl_if;

  logic       SMPL;
  logic [2:0] KEYIN;
  logic       MODE;
  logic       SELECT;
  logic       ADJUST;
  logic       KEYACT;

  modport master (output SMPL, KEYIN, input MODE, SELECT, ADJUST, KEYACT);
  modport slave  (input SMPL, KEYIN, output MODE, SELECT, ADJUST, KEYACT);

endinterface

// File: rtl/clock_key_ctrl_debounce.sv
// Single-key debouncer: 2-FF synchroniser, DBNC-deep sample history and a
// debounced level with a one-cycle rising-edge strobe.
module key_debounce #(
  parameter int DBNC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic smpl,
  input  logic key_n,
  output logic level,
  output logic rise
);

  logic [1:0]      sync_q, sync_d;
  logic [DBNC-1:0] hist_q, hist_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  // The level decision looks at the freshly shifted history so it flips on
  // the same sample edge that completes the run of equal samples.
  always_comb begin
    sync_d  = sync_q;
    hist_d  = hist_q;
    level_d = level_q;
    if (smpl) begin
      sync_d = {sync_q[0], ~key_n};
      hist_d = {hist_q[DBNC-2:0], sync_q[1]};
      if (&hist_d && !level_q) begin
        level_d = 1'b1;
      end else if (~|hist_d && level_q) begin
        level_d = 1'b0;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/clock_key_ctrl.sv
// Key front-end for the 24-hour clock: debounce, one-command-per-cycle
// priority and, when KEY_REPEAT_EN is defined, ADJUST auto-repeat.
module clock_key_ctrl
  import clock_pkg::*;
#(
  parameter int DBNC   = DEF_DBNC,
  parameter int REPDLY = DEF_REPDLY,
  parameter int REPINT = DEF_REPINT,
  parameter int CW     = DEF_CW
) (
  input  logic             CLK,
  input  logic             RST,
  clock_key_ctrl_if.slave  key_if
);

  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] rise;
  logic             ev_mode, ev_select, ev_adjust;
  logic             mode_q, mode_d;
  logic             select_q, select_d;
  logic             adjust_q, adjust_d;

  if (DBNC < 2 || DBNC > 8 || REPDLY < 2 || REPINT < 2 ||
      (64'd1 << CW) <= 64'(REPDLY) || (64'd1 << CW) <= 64'(REPINT)) begin : g_bad_cfg
    $error("clock_key_ctrl: illegal parameter combination");
  end

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debounce #(.DBNC(DBNC)) u_dbnc (
      .clk   (CLK),
      .rst_n (RST),
      .smpl  (key_if.SMPL),
      .key_n (key_if.KEYIN[k]),
      .level (level[k]),
      .rise  (rise[k])
    );
  end

  // Lower-priority press events in the same cycle are dropped outright.
  assign ev_mode   = rise[K_MODE];
  assign ev_select = rise[K_SELECT] & ~rise[K_MODE];
  assign ev_adjust = rise[K_ADJUST] & ~rise[K_MODE] & ~rise[K_SELECT];

  assign mode_d   = ev_mode;
  assign select_d = ev_select;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(REPDLY - 1);
  localparam logic [CW-1:0] INT_LAST = CW'(REPINT - 1);

  rep_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_last;

  assign cnt_last = (state_q == R_DELAY) ? DLY_LAST : INT_LAST;

  // Every state change clears the counter, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adjust_d = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (ev_adjust) begin
          adjust_d = 1'b1;
          cnt_d    = '0;
          state_d  = R_DELAY;
        end
      end
      R_DELAY, R_REPEAT: begin
        if (!level[K_ADJUST]) begin
          cnt_d   = '0;
          state_d = R_IDLE;
        end else if (ev_mode || ev_select) begin
          cnt_d   = '0;
          state_d = R_LOCK;
        end else if (key_if.SMPL) begin
          if (cnt_q == cnt_last) begin
            adjust_d = 1'b1;
            cnt_d    = '0;
            state_d  = R_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      R_LOCK: begin
        if (!level[K_ADJUST]) begin
          cnt_d   = '0;
          state_d = R_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign adjust_d = ev_adjust;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode_q   <= 1'b0;
      select_q <= 1'b0;
      adjust_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      select_q <= select_d;
      adjust_q <= adjust_d;
    end
  end

  assign key_if.MODE   = mode_q;
  assign key_if.SELECT = select_q;
  assign key_if.ADJUST = adjust_q;
  assign key_if.KEYACT = |level;

endmodule

// File: tb/tb_clock_key_ctrl.sv
// Directed bench for clock_key_ctrl (DBNC=3, REPDLY=50, REPINT=10, SMPL every
// 4 clocks); expectations follow the KEY_REPEAT_EN build setting.
module tb_clock_key_ctrl;

`ifdef KEY_REPEAT_EN
  localparam int EXP_HOLD  = 8;
  localparam int EXP_AT55  = 2;
  localparam int EXP_LOCK  = 3;
  localparam int EXP_PULSE = 1;
`else
  localparam int EXP_HOLD  = 1;
  localparam int EXP_AT55  = 1;
  localparam int EXP_LOCK  = 1;
  localparam int EXP_PULSE = 0;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;
  int   cnt_mode = 0, cnt_select = 0, cnt_adjust = 0, cnt_multi = 0;
  int   base_mode, base_select, base_adjust;

  clock_key_ctrl_if key_if ();

  clock_key_ctrl #(.DBNC(3), .REPDLY(50), .REPINT(10), .CW(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .key_if (key_if)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (key_if.MODE === 1'b1) cnt_mode++;
    if (key_if.SELECT === 1'b1) cnt_select++;
    if (key_if.ADJUST === 1'b1) cnt_adjust++;
    if (int'(key_if.MODE) + int'(key_if.SELECT) + int'(key_if.ADJUST) > 1) cnt_multi++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Holds KEYIN at the given raw value for n sample periods of 4 clocks.
  task automatic applyStimulus(input logic [2:0] keys, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      key_if.KEYIN = keys;
      key_if.SMPL  = 1'b1;
      @(negedge CLK);
      key_if.SMPL  = 1'b0;
      repeat (2) @(negedge CLK);
    end
  endtask

  task automatic markCounts();
    base_mode   = cnt_mode;
    base_select = cnt_select;
    base_adjust = cnt_adjust;
  endtask

  initial begin
    RST          = 1'b0;
    key_if.KEYIN = 3'b111;
    key_if.SMPL  = 1'b0;
    #23;
    checkOutput("reset_outputs",
                {28'd0, key_if.MODE, key_if.SELECT, key_if.ADJUST, key_if.KEYACT}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    applyStimulus(3'b111, 4);

    markCounts();
    applyStimulus(3'b110, 4);
    checkOutput("mode_not_early", cnt_mode - base_mode, 0);
    applyStimulus(3'b110, 1);
    checkOutput("mode_latency", cnt_mode - base_mode, 1);
    checkOutput("keyact_pressed", {31'd0, key_if.KEYACT}, 1);
    applyStimulus(3'b110, 10);
    checkOutput("mode_single", cnt_mode - base_mode, 1);
    checkOutput("mode_others_quiet", (cnt_select - base_select) + (cnt_adjust - base_adjust), 0);
    applyStimulus(3'b111, 8);
    checkOutput("mode_release_no_pulse", cnt_mode - base_mode, 1);
    checkOutput("keyact_released", {31'd0, key_if.KEYACT}, 0);

    markCounts();
    applyStimulus(3'b101, 1);
    applyStimulus(3'b111, 1);
    applyStimulus(3'b101, 1);
    applyStimulus(3'b111, 1);
    applyStimulus(3'b101, 1);
    applyStimulus(3'b101, 3);
    checkOutput("select_bounce_quiet", cnt_select - base_select, 0);
    applyStimulus(3'b101, 1);
    checkOutput("select_after_stable", cnt_select - base_select, 1);
    applyStimulus(3'b101, 10);
    checkOutput("select_single", cnt_select - base_select, 1);
    applyStimulus(3'b111, 8);

    markCounts();
    applyStimulus(3'b010, 60);
    checkOutput("same_sample_mode", cnt_mode - base_mode, 1);
    checkOutput("same_sample_adj_dropped", cnt_adjust - base_adjust, 0);
    applyStimulus(3'b111, 8);
    markCounts();
    applyStimulus(3'b011, 5);
    checkOutput("adj_repress", cnt_adjust - base_adjust, 1);
    applyStimulus(3'b111, 8);

    markCounts();
    applyStimulus(3'b011, 54);
    checkOutput("hold_before_delay", cnt_adjust - base_adjust, 1);
    applyStimulus(3'b011, 1);
    checkOutput("hold_first_repeat", cnt_adjust - base_adjust, EXP_AT55);
    applyStimulus(3'b011, 62);
    applyStimulus(3'b111, 20);
    checkOutput("hold_total", cnt_adjust - base_adjust, EXP_HOLD);
    applyStimulus(3'b111, 60);
    checkOutput("hold_after_release", cnt_adjust - base_adjust, EXP_HOLD);

    markCounts();
    applyStimulus(3'b011, 68);
    checkOutput("lock_before_select", cnt_adjust - base_adjust, EXP_LOCK);
    applyStimulus(3'b001, 4);
    checkOutput("lock_select_early", cnt_select - base_select, 0);
    applyStimulus(3'b001, 1);
    checkOutput("lock_select_pulse", cnt_select - base_select, 1);
    applyStimulus(3'b001, 40);
    checkOutput("lock_adj_stopped", cnt_adjust - base_adjust, EXP_LOCK);
    applyStimulus(3'b111, 8);
    markCounts();
    applyStimulus(3'b011, 5);
    checkOutput("adj_after_lock", cnt_adjust - base_adjust, 1);

    applyStimulus(3'b011, 59);
    @(negedge CLK);
    key_if.SMPL = 1'b1;
    @(posedge CLK);
    #3;
    checkOutput("pre_reset_repeat", {31'd0, key_if.ADJUST}, EXP_PULSE);
    checkOutput("pre_reset_keyact", {31'd0, key_if.KEYACT}, 1);
    RST = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {28'd0, key_if.MODE, key_if.SELECT, key_if.ADJUST, key_if.KEYACT}, 32'd0);
    @(negedge CLK);
    key_if.SMPL = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    markCounts();
    applyStimulus(3'b011, 4);
    checkOutput("held_through_reset_early", cnt_adjust - base_adjust, 0);
    applyStimulus(3'b011, 1);
    checkOutput("held_through_reset_press", cnt_adjust - base_adjust, 1);
    applyStimulus(3'b111, 8);

    checkOutput("one_hot_outputs", cnt_multi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
